// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_if
// Description : Bundles every reorder buffer signal except clk/rst/rdy.
//               The decode, completion-bus, dispatch-lookup and commit
//               groups all travel together.
//               master : the pipeline side (decode / CDB / dispatch / RF)
//               slave  : the reorder buffer itself
// Ports       : alloc_* (ID request + returned tag, rob_full)
//               cdb_*   (completion broadcast)
//               q1_* / q2_* (operand lookups)
//               ROB_*   (register file commit), clear / clear_pc (flush)
// Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if #(
  parameter int TAG_W = 5
);
  logic             alloc_req;
  logic [4:0]       alloc_reg_dest;
  logic             alloc_is_branch;
  logic             alloc_pred_taken;
  logic [31:0]      alloc_alt_pc;
  logic [TAG_W-1:0] alloc_tag;
  logic             rob_full;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_taken;

  logic [TAG_W-1:0] q1_tag;
  logic [TAG_W-1:0] q2_tag;
  logic             q1_ready;
  logic             q2_ready;
  logic [31:0]      q1_data;
  logic [31:0]      q2_data;

  logic             ROB_data_valid;
  logic [4:0]       ROB_reg_dest;
  logic [TAG_W-1:0] ROB_tag;
  logic [31:0]      ROB_data;
  logic             clear;
  logic [31:0]      clear_pc;

  modport master (
    output alloc_req, alloc_reg_dest, alloc_is_branch, alloc_pred_taken, alloc_alt_pc,
    output cdb_valid, cdb_tag, cdb_data, cdb_taken,
    output q1_tag, q2_tag,
    input  alloc_tag, rob_full, q1_ready, q2_ready, q1_data, q2_data,
    input  ROB_data_valid, ROB_reg_dest, ROB_tag, ROB_data, clear, clear_pc
  );

  modport slave (
    input  alloc_req, alloc_reg_dest, alloc_is_branch, alloc_pred_taken, alloc_alt_pc,
    input  cdb_valid, cdb_tag, cdb_data, cdb_taken,
    input  q1_tag, q2_tag,
    output alloc_tag, rob_full, q1_ready, q2_ready, q1_data, q2_data,
    output ROB_data_valid, ROB_reg_dest, ROB_tag, ROB_data, clear, clear_pc
  );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Circular in-order retirement buffer. Hands out rename tags
//               (entry index + 1, 0 = no producer), captures CDB results by
//               tag, retires one entry per cycle to the register file and
//               raises a one-cycle flush with redirect PC when a retiring
//               branch turns out mispredicted.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-low reset
//               rdy  - global enable, all state holds while low
//               bus  - reorder_buffer_if.slave (alloc / CDB / query / commit)
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int IDX_W    = 4,
  parameter int TAG_W    = 5
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         rdy,
  reorder_buffer_if.slave   bus
);

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [4:0]  reg_dest;
    logic        is_branch;
    logic        pred_taken;
    logic [31:0] alt_pc;
    logic [31:0] data;
    logic        taken;
  } entry_t;

  entry_t           rob_q [ROB_SIZE];
  entry_t           rob_d [ROB_SIZE];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic             rob_valid_q, rob_valid_d;
  logic [4:0]       rob_dest_q, rob_dest_d;
  logic [TAG_W-1:0] rob_tag_q, rob_tag_d;
  logic [31:0]      rob_data_q, rob_data_d;
  logic             clear_q, clear_d;
  logic [31:0]      clear_pc_q, clear_pc_d;

  logic             do_commit;
  logic             do_alloc;
  logic             cdb_hit;
  logic             mispredict;
  logic             full;

  // Tags outside 1..ROB_SIZE never name an entry.
  function automatic logic tag_ok(input logic [TAG_W-1:0] t);
    tag_ok = (int'(t) >= 1) && (int'(t) <= ROB_SIZE);
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
    logic [TAG_W-1:0] m;
    m       = t - TAG_W'(1);
    tag_idx = m[IDX_W-1:0];
  endfunction

  assign full          = (count_q == (IDX_W+1)'(ROB_SIZE));
  assign bus.rob_full  = full;
  assign bus.alloc_tag = TAG_W'(tail_q) + TAG_W'(1);

  assign bus.ROB_data_valid = rob_valid_q;
  assign bus.ROB_reg_dest   = rob_dest_q;
  assign bus.ROB_tag        = rob_tag_q;
  assign bus.ROB_data       = rob_data_q;
  assign bus.clear          = clear_q;
  assign bus.clear_pc       = clear_pc_q;

  // Next-state: everything holds unless rdy; a pending clear swallows the
  // whole cycle; a mispredicted commit wipes the buffer and discards the
  // same-edge alloc and CDB.
  always_comb begin
    rob_d       = rob_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    rob_valid_d = rob_valid_q;
    rob_dest_d  = rob_dest_q;
    rob_tag_d   = rob_tag_q;
    rob_data_d  = rob_data_q;
    clear_d     = clear_q;
    clear_pc_d  = clear_pc_q;
    do_commit   = 1'b0;
    do_alloc    = 1'b0;
    cdb_hit     = 1'b0;
    mispredict  = 1'b0;

    if (rdy) begin
      if (clear_q) begin
        clear_d     = 1'b0;
        rob_valid_d = 1'b0;
      end else begin
        do_commit  = (count_q != '0) && rob_q[head_q].ready;
        mispredict = do_commit && rob_q[head_q].is_branch &&
                     (rob_q[head_q].taken != rob_q[head_q].pred_taken);
        do_alloc   = bus.alloc_req && !full;
        cdb_hit    = bus.cdb_valid && tag_ok(bus.cdb_tag) &&
                     rob_q[tag_idx(bus.cdb_tag)].busy;

        rob_valid_d = do_commit && (rob_q[head_q].reg_dest != 5'd0);
        if (do_commit) begin
          rob_dest_d          = rob_q[head_q].reg_dest;
          rob_tag_d           = TAG_W'(head_q) + TAG_W'(1);
          rob_data_d          = rob_q[head_q].data;
          rob_d[head_q].busy  = 1'b0;
          head_d              = head_q + IDX_W'(1);
        end

        clear_d = mispredict;
        if (mispredict) begin
          clear_pc_d = rob_q[head_q].alt_pc;
          head_d     = '0;
          tail_d     = '0;
          count_d    = '0;
          for (int i = 0; i < ROB_SIZE; i++) begin
            rob_d[i].busy = 1'b0;
          end
        end else begin
          if (cdb_hit) begin
            rob_d[tag_idx(bus.cdb_tag)].ready = 1'b1;
            rob_d[tag_idx(bus.cdb_tag)].data  = bus.cdb_data;
            rob_d[tag_idx(bus.cdb_tag)].taken = bus.cdb_taken;
          end
          // The tail slot is never busy when not full, so it cannot collide
          // with the CDB write above.
          if (do_alloc) begin
            rob_d[tail_q].busy       = 1'b1;
            rob_d[tail_q].ready      = 1'b0;
            rob_d[tail_q].reg_dest   = bus.alloc_reg_dest;
            rob_d[tail_q].is_branch  = bus.alloc_is_branch;
            rob_d[tail_q].pred_taken = bus.alloc_pred_taken;
            rob_d[tail_q].alt_pc     = bus.alloc_alt_pc;
            tail_d                   = tail_q + IDX_W'(1);
          end
          count_d = count_q + {{IDX_W{1'b0}}, do_alloc} - {{IDX_W{1'b0}}, do_commit};
        end
      end
    end
  end

  // Operand lookups: a same-cycle CDB broadcast bypasses the stored value.
  always_comb begin
    bus.q1_ready = 1'b0;
    bus.q1_data  = '0;
    if (tag_ok(bus.q1_tag) && rob_q[tag_idx(bus.q1_tag)].busy) begin
      if (bus.cdb_valid && (bus.cdb_tag == bus.q1_tag)) begin
        bus.q1_ready = 1'b1;
        bus.q1_data  = bus.cdb_data;
      end else begin
        bus.q1_ready = rob_q[tag_idx(bus.q1_tag)].ready;
        bus.q1_data  = rob_q[tag_idx(bus.q1_tag)].data;
      end
    end
  end

  always_comb begin
    bus.q2_ready = 1'b0;
    bus.q2_data  = '0;
    if (tag_ok(bus.q2_tag) && rob_q[tag_idx(bus.q2_tag)].busy) begin
      if (bus.cdb_valid && (bus.cdb_tag == bus.q2_tag)) begin
        bus.q2_ready = 1'b1;
        bus.q2_data  = bus.cdb_data;
      end else begin
        bus.q2_ready = rob_q[tag_idx(bus.q2_tag)].ready;
        bus.q2_data  = rob_q[tag_idx(bus.q2_tag)].data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rob_valid_q <= 1'b0;
      rob_dest_q  <= '0;
      rob_tag_q   <= '0;
      rob_data_q  <= '0;
      clear_q     <= 1'b0;
      clear_pc_q  <= '0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob_q[i] <= rob_d[i];
      end
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rob_valid_q <= rob_valid_d;
      rob_dest_q  <= rob_dest_d;
      rob_tag_q   <= rob_tag_d;
      rob_data_q  <= rob_data_d;
      clear_q     <= clear_d;
      clear_pc_q  <= clear_pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Directed scenarios plus a randomized run checked against a
//               queue-based model of in-order retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_W(5)) bus ();

  reorder_buffer #(.ROB_SIZE(16), .IDX_W(4), .TAG_W(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  dest;
    logic        br;
    logic        pred;
    logic [31:0] alt;
    logic        has;
    logic [31:0] data;
    logic        taken;
    logic [4:0]  tag;
  } ment_t;

  ment_t mq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_req        = 1'b0;
    bus.alloc_reg_dest   = 5'd0;
    bus.alloc_is_branch  = 1'b0;
    bus.alloc_pred_taken = 1'b0;
    bus.alloc_alt_pc     = 32'd0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_tag          = 5'd0;
    bus.cdb_data         = 32'd0;
    bus.cdb_taken        = 1'b0;
    bus.q1_tag           = 5'd0;
    bus.q2_tag           = 5'd0;
  endtask

  task automatic do_reset();
    idle();
    rdy = 1'b1;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic alloc_one(input logic [4:0] d);
    bus.alloc_req      = 1'b1;
    bus.alloc_reg_dest = d;
    tick();
    bus.alloc_req      = 1'b0;
  endtask

  task automatic cdb_one(input logic [4:0] t, input logic [31:0] d, input logic tk);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
    bus.cdb_taken = tk;
    tick();
    bus.cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (bus.rob_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", bus.rob_full); end
    n_vec++; if (bus.alloc_tag !== 5'd1) begin n_err++; $display("FAIL reset_alloc_tag got %0d want 1", bus.alloc_tag); end
    n_vec++; if ({bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data, bus.clear, bus.clear_pc} !== '0) begin
      n_err++; $display("FAIL reset_regs got v=%0b d=%0d t=%0d data=%h c=%0b pc=%h want all 0",
        bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data, bus.clear, bus.clear_pc); end
  endtask

  task automatic test_in_order();
    do_reset();
    bus.alloc_req = 1'b1; bus.alloc_reg_dest = 5'd5; #1;
    n_vec++; if (bus.alloc_tag !== 5'd1) begin n_err++; $display("FAIL order_tag1 got %0d want 1", bus.alloc_tag); end
    tick();
    bus.alloc_reg_dest = 5'd6; #1;
    n_vec++; if (bus.alloc_tag !== 5'd2) begin n_err++; $display("FAIL order_tag2 got %0d want 2", bus.alloc_tag); end
    tick();
    bus.alloc_req = 1'b0;
    cdb_one(5'd2, 32'h22, 1'b0);
    n_vec++; if (bus.ROB_data_valid !== 1'b0) begin n_err++; $display("FAIL order_early got %0b want 0", bus.ROB_data_valid); end
    cdb_one(5'd1, 32'h11, 1'b0);
    tick();
    n_vec++; if ({bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data} !== {1'b1, 5'd5, 5'd1, 32'h11}) begin
      n_err++; $display("FAIL order_c1 got v=%0b d=%0d t=%0d data=%h want 1/5/1/11", bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data); end
    tick();
    n_vec++; if ({bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data} !== {1'b1, 5'd6, 5'd2, 32'h22}) begin
      n_err++; $display("FAIL order_c2 got v=%0b d=%0d t=%0d data=%h want 1/6/2/22", bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data); end
    tick();
    bus.q1_tag = 5'd1; bus.q2_tag = 5'd2; #1;
    n_vec++; if ({bus.ROB_data_valid, bus.q1_ready, bus.q2_ready, bus.alloc_tag} !== {3'b000, 5'd3}) begin
      n_err++; $display("FAIL order_drain got v=%0b q1r=%0b q2r=%0b tag=%0d want 0/0/0/3", bus.ROB_data_valid, bus.q1_ready, bus.q2_ready, bus.alloc_tag); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) alloc_one(5'(i + 1));
    bus.alloc_req = 1'b1; bus.alloc_reg_dest = 5'd30; #1;
    n_vec++; if ({bus.rob_full, bus.alloc_tag} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL full_set got full=%0b tag=%0d want 1/1", bus.rob_full, bus.alloc_tag); end
    tick();
    bus.alloc_req = 1'b0;
    cdb_one(5'd1, 32'hAA, 1'b0);
    tick();
    n_vec++; if ({bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_tag} !== {1'b1, 5'd1, 5'd1}) begin
      n_err++; $display("FAIL full_commit got v=%0b d=%0d t=%0d want 1/1/1 (17th must be dropped)", bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_tag); end
    n_vec++; if ({bus.rob_full, bus.alloc_tag} !== {1'b0, 5'd1}) begin n_err++; $display("FAIL full_wrap got full=%0b tag=%0d want 0/1", bus.rob_full, bus.alloc_tag); end
    alloc_one(5'd20);
    n_vec++; if (bus.rob_full !== 1'b1) begin n_err++; $display("FAIL full_refill got %0b want 1", bus.rob_full); end
  endtask

  task automatic test_query_bypass();
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(5'(i + 8));
    bus.q1_tag = 5'd3; bus.q2_tag = 5'd2;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd3; bus.cdb_data = 32'hABCD; #1;
    n_vec++; if ({bus.q1_ready, bus.q1_data} !== {1'b1, 32'hABCD}) begin n_err++; $display("FAIL q_bypass got r=%0b d=%h want 1/abcd", bus.q1_ready, bus.q1_data); end
    n_vec++; if (bus.q2_ready !== 1'b0) begin n_err++; $display("FAIL q_other got %0b want 0", bus.q2_ready); end
    tick();
    bus.cdb_valid = 1'b0; #1;
    n_vec++; if ({bus.q1_ready, bus.q1_data} !== {1'b1, 32'hABCD}) begin n_err++; $display("FAIL q_stored got r=%0b d=%h want 1/abcd", bus.q1_ready, bus.q1_data); end
  endtask

  task automatic test_mispredict();
    do_reset();
    bus.alloc_is_branch = 1'b1; bus.alloc_pred_taken = 1'b0; bus.alloc_alt_pc = 32'h1000;
    alloc_one(5'd7);
    bus.alloc_is_branch = 1'b0; bus.alloc_alt_pc = 32'h0;
    for (int i = 0; i < 3; i++) alloc_one(5'(i + 1));
    cdb_one(5'd1, 32'h77, 1'b1);
    tick();
    n_vec++; if ({bus.clear, bus.clear_pc} !== {1'b1, 32'h1000}) begin n_err++; $display("FAIL mp_clear got c=%0b pc=%h want 1/1000", bus.clear, bus.clear_pc); end
    n_vec++; if ({bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_data} !== {1'b1, 5'd7, 32'h77}) begin
      n_err++; $display("FAIL mp_write got v=%0b d=%0d data=%h want 1/7/77", bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_data); end
    bus.alloc_req = 1'b1; bus.alloc_reg_dest = 5'd9;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd2; bus.cdb_data = 32'h5;
    tick();
    idle();
    bus.q1_tag = 5'd2; bus.q2_tag = 5'd1; #1;
    n_vec++; if ({bus.clear, bus.ROB_data_valid, bus.rob_full, bus.alloc_tag} !== {3'b000, 5'd1}) begin
      n_err++; $display("FAIL mp_after got c=%0b v=%0b full=%0b tag=%0d want 0/0/0/1", bus.clear, bus.ROB_data_valid, bus.rob_full, bus.alloc_tag); end
    n_vec++; if ({bus.q1_ready, bus.q2_ready} !== 2'b00) begin n_err++; $display("FAIL mp_flushed got q1r=%0b q2r=%0b want 0/0", bus.q1_ready, bus.q2_ready); end
  endtask

  task automatic test_x0_and_free();
    do_reset();
    alloc_one(5'd0);
    cdb_one(5'd1, 32'h5, 1'b0);
    tick();
    n_vec++; if ({bus.ROB_data_valid, bus.ROB_tag, bus.ROB_data} !== {1'b0, 5'd1, 32'h5}) begin
      n_err++; $display("FAIL x0_commit got v=%0b t=%0d data=%h want 0/1/5", bus.ROB_data_valid, bus.ROB_tag, bus.ROB_data); end
    cdb_one(5'd4, 32'h9, 1'b0);
    bus.q1_tag = 5'd4; bus.q2_tag = 5'd1; #1;
    n_vec++; if ({bus.q1_ready, bus.q2_ready, bus.ROB_data_valid, bus.rob_full, bus.alloc_tag} !== {4'b0000, 5'd2}) begin
      n_err++; $display("FAIL free_cdb got q1r=%0b q2r=%0b v=%0b full=%0b tag=%0d want 0/0/0/0/2",
        bus.q1_ready, bus.q2_ready, bus.ROB_data_valid, bus.rob_full, bus.alloc_tag); end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    alloc_one(5'd3);
    cdb_one(5'd1, 32'h33, 1'b0);
    rdy = 1'b0; bus.alloc_req = 1'b1; bus.alloc_reg_dest = 5'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if ({bus.ROB_data_valid, bus.alloc_tag} !== {1'b0, 5'd2}) begin
        n_err++; $display("FAIL hold_%0d got v=%0b tag=%0d want 0/2", i, bus.ROB_data_valid, bus.alloc_tag); end
    end
    rdy = 1'b1; bus.alloc_req = 1'b0;
    tick();
    n_vec++; if ({bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_data} !== {1'b1, 5'd3, 32'h33}) begin
      n_err++; $display("FAIL hold_release got v=%0b d=%0d data=%h want 1/3/33", bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_data); end
    rdy = 1'b0;
    repeat (2) tick();
    n_vec++; if (bus.ROB_data_valid !== 1'b1) begin n_err++; $display("FAIL hold_strobe got %0b want 1", bus.ROB_data_valid); end
    rdy = 1'b1;
    tick();
    n_vec++; if (bus.ROB_data_valid !== 1'b0) begin n_err++; $display("FAIL hold_consumed got %0b want 0", bus.ROB_data_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) alloc_one(5'(i + 10));
    cdb_one(5'd1, 32'h44, 1'b0);
    tick();
    bus.q1_tag = 5'd2;
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if ({bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data, bus.clear, bus.clear_pc} !== '0) begin
      n_err++; $display("FAIL arst_regs got v=%0b d=%0d t=%0d data=%h c=%0b want all 0", bus.ROB_data_valid, bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data, bus.clear); end
    n_vec++; if ({bus.rob_full, bus.q1_ready, bus.alloc_tag} !== {2'b00, 5'd1}) begin
      n_err++; $display("FAIL arst_state got full=%0b q1r=%0b tag=%0d want 0/0/1", bus.rob_full, bus.q1_ready, bus.alloc_tag); end
    #3;
    rst = 1'b1;
    idle();
  endtask

  function automatic int find_tag(input logic [4:0] t);
    for (int i = 0; i < mq.size(); i++) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  task automatic test_random();
    int          next_tag;
    logic        e_valid, e_clear, e_loaded;
    logic [4:0]  e_dest, e_tag;
    logic [31:0] e_data, e_pc;
    logic        full_pre, e_r;
    logic [31:0] e_d;
    int          k;
    do_reset();
    mq.delete();
    next_tag = 1;
    e_valid = 0; e_clear = 0; e_dest = 0; e_tag = 0; e_data = 0; e_pc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy                  = ($urandom_range(0, 9) != 0);
      bus.alloc_req        = ($urandom_range(0, 2) != 0);
      bus.alloc_reg_dest   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.alloc_is_branch  = ($urandom_range(0, 4) == 0);
      bus.alloc_pred_taken = 1'($urandom_range(0, 1));
      bus.alloc_alt_pc     = $urandom;
      bus.cdb_valid        = ($urandom_range(0, 3) != 0);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0)
        bus.cdb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        bus.cdb_tag = 5'($urandom_range(0, 31));
      bus.cdb_data  = $urandom;
      bus.cdb_taken = ($urandom_range(0, 5) == 0);
      bus.q1_tag    = 5'($urandom_range(0, 17));
      bus.q2_tag    = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : 5'd0;
      #1;
      n_vec++; if ({bus.rob_full, bus.alloc_tag} !== {(mq.size() == 16), 5'(next_tag)}) begin
        n_err++; $display("FAIL rnd_alloc cyc %0d got full=%0b tag=%0d want %0b/%0d", cyc, bus.rob_full, bus.alloc_tag, (mq.size() == 16), next_tag); end
      for (int p = 0; p < 2; p++) begin
        logic [4:0] qt;
        qt = (p == 0) ? bus.q1_tag : bus.q2_tag;
        k = find_tag(qt);
        e_r = 1'b0; e_d = 32'd0;
        if (k >= 0) begin
          if (bus.cdb_valid && bus.cdb_tag == qt) begin e_r = 1'b1; e_d = bus.cdb_data; end
          else begin e_r = mq[k].has; e_d = mq[k].data; end
        end
        n_vec++;
        if (((p == 0) ? bus.q1_ready : bus.q2_ready) !== e_r ||
            (e_r && ((p == 0) ? bus.q1_data : bus.q2_data) !== e_d)) begin
          n_err++; $display("FAIL rnd_query%0d cyc %0d tag %0d got r=%0b d=%h want r=%0b d=%h", p + 1, cyc, qt,
            (p == 0) ? bus.q1_ready : bus.q2_ready, (p == 0) ? bus.q1_data : bus.q2_data, e_r, e_d); end
      end
      // Reference behaviour at the coming edge.
      e_loaded = 1'b0;
      if (rdy) begin
        if (e_clear) begin
          e_clear = 1'b0; e_valid = 1'b0;
        end else begin
          logic mis;
          full_pre = (mq.size() == 16);
          mis = 1'b0;
          e_valid = 1'b0;
          if (mq.size() > 0 && mq[0].has) begin
            e_loaded = 1'b1;
            e_valid  = (mq[0].dest != 5'd0);
            e_dest   = mq[0].dest; e_tag = mq[0].tag; e_data = mq[0].data;
            mis      = mq[0].br && (mq[0].taken != mq[0].pred);
            e_pc     = mis ? mq[0].alt : e_pc;
            void'(mq.pop_front());
          end
          e_clear = mis;
          if (mis) begin
            mq.delete();
            next_tag = 1;
          end else begin
            k = bus.cdb_valid ? find_tag(bus.cdb_tag) : -1;
            if (k >= 0) begin mq[k].has = 1'b1; mq[k].data = bus.cdb_data; mq[k].taken = bus.cdb_taken; end
            if (bus.alloc_req && !full_pre) begin
              mq.push_back('{bus.alloc_reg_dest, bus.alloc_is_branch, bus.alloc_pred_taken,
                             bus.alloc_alt_pc, 1'b0, 32'd0, 1'b0, 5'(next_tag)});
              next_tag = (next_tag % 16) + 1;
            end
          end
        end
      end
      tick();
      n_vec++; if ({bus.ROB_data_valid, bus.clear} !== {e_valid, e_clear}) begin
        n_err++; $display("FAIL rnd_strobe cyc %0d got v=%0b c=%0b want %0b/%0b", cyc, bus.ROB_data_valid, bus.clear, e_valid, e_clear); end
      if (e_clear) begin
        n_vec++; if (bus.clear_pc !== e_pc) begin n_err++; $display("FAIL rnd_pc cyc %0d got %h want %h", cyc, bus.clear_pc, e_pc); end
      end
      if (e_loaded) begin
        n_vec++; if ({bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data} !== {e_dest, e_tag, e_data}) begin
          n_err++; $display("FAIL rnd_commit cyc %0d got d=%0d t=%0d data=%h want d=%0d t=%0d data=%h",
            cyc, bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data, e_dest, e_tag, e_data); end
      end
    end
    idle();
    rdy = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_in_order();
    test_full_wrap();
    test_query_bypass();
    test_mispredict();
    test_x0_and_free();
    test_rdy_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer between decode (ID), the completion bus (CDB) and the register file.
- Hands a rename tag to each decoded instruction and captures out-of-order results by tag.
- Retires at most one instruction per cycle through the register file commit interface (ROB_data_valid/ROB_reg_dest/ROB_tag/ROB_data).
- On a branch mispredict at retirement, issues the pipeline-wide clear and the redirect PC.

Parameters:
- ROB_SIZE, 16, number of entries; must be a power of two.
- IDX_W, 4, log2(ROB_SIZE).
- TAG_W, 5, tag width. Tag = entry index + 1, so tags run 1..ROB_SIZE and tag 0 means "no producer".

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rdy  in  1  global enable; when low, all state holds.
- alloc_req  in  1  ID requests an entry this cycle.
- alloc_reg_dest  in  5  destination register (0 = none).
- alloc_is_branch  in  1  entry is a conditional branch.
- alloc_pred_taken  in  1  predicted direction.
- alloc_alt_pc  in  32  PC to fetch if the prediction proves wrong.
- alloc_tag  out  TAG_W  tag for the current request (combinational, tail+1).
- rob_full  out  1  combinational; count == ROB_SIZE.
- cdb_valid  in  1  a result is broadcast.
- cdb_tag  in  TAG_W  tag of the producing entry.
- cdb_data  in  32  result value.
- cdb_taken  in  1  actual branch direction (ignored for non-branches).
- q1_tag, q2_tag  in  TAG_W  dispatch operand lookups.
- q1_ready, q2_ready  out  1  entry has its result, or a CDB hit this cycle.
- q1_data, q2_data  out  32  that result.
- ROB_data_valid  out  1  registered commit strobe to the register file.
- ROB_reg_dest  out  5  committed destination register.
- ROB_tag  out  TAG_W  tag of the committed entry.
- ROB_data  out  32  committed value.
- clear  out  1  registered one-cycle flush pulse.
- clear_pc  out  32  redirect PC, valid while clear = 1.

Behaviour:
- Reset (rst = 0, asynchronous):
  - head, tail and count clear to 0; every entry's busy and ready bits clear to 0.
  - All registered outputs clear to 0.
- rdy = 0: no state or output register changes. A held ROB_data_valid = 1 is consumed exactly once, by the register file, at the first edge where rdy = 1.
- Allocate: on an edge with rdy, alloc_req = 1, !rob_full and clear = 0:
  - Entry[tail] is written with busy = 1, ready = 0, and all alloc_* fields.
  - tail advances with wrap from ROB_SIZE-1 to 0.
  - Requests while full or while clear = 1 are dropped; ID must stall on rob_full.
- Complete: cdb_valid = 1 with clear = 0, cdb_tag != 0, and entry[cdb_tag-1] busy:
  - Store data and taken, and set ready at the edge.
  - A CDB hit on a non-busy entry or on tag 0 is ignored.
- Commit: at an edge with rdy, count > 0, entry[head] ready and clear = 0:
  - ROB_data_valid <= (reg_dest != 0); ROB_reg_dest, ROB_tag (= head+1) and ROB_data are loaded.
  - entry[head].busy <= 0 and head advances.
  - If no commit occurs, ROB_data_valid <= 0.
  - Minimum latency is one cycle from the CDB edge that sets ready to the commit edge; the register file sees the write one cycle later.
- Count: alloc and commit at the same edge leave count unchanged. Alloc of the just-freed slot is legal only after the commit edge.
- Mispredict: a committing branch with taken != pred_taken triggers, at that edge:
  - clear <= 1 and clear_pc <= alt_pc.
  - head, tail and count <= 0 and all busy <= 0; same-edge alloc and CDB are discarded.
  - A non-branch or correctly predicted commit sets clear <= 0.
  - The branch's own write still commits if reg_dest != 0.
- While clear = 1: alloc, CDB and commit are ignored; clear deasserts after exactly one cycle.
- Query (combinational), per port:
  - qN_tag = 0 or entry not busy -> ready 0, data 0.
  - Otherwise, a CDB hit on that tag this cycle -> ready 1, data = cdb_data.
  - Otherwise -> the entry's ready bit and stored data.

Test Plan:
- Reset, then allocate dest x5 (tag 1) and x6 (tag 2). CDB tag 2 = 0x22, then tag 1 = 0x11.
  -> Commits in order: x5/1/0x11, then x6/2/0x22, on consecutive cycles; count returns to 0.
- Allocate 16 entries with no CDB traffic -> rob_full = 1; a 17th alloc_req is dropped.
  - Complete and commit tag 1, then allocate again -> alloc_tag = 1 (wrap-around).
- Query q1_tag = 3 while CDB broadcasts tag 3 = 0xABCD in the same cycle -> q1_ready = 1, q1_data = 0xABCD.
  - Next cycle, from storage -> the same value.
- Branch (tag 1, pred_taken = 0, alt_pc = 0x1000) plus 3 younger entries; CDB tag 1 with taken = 1.
  -> clear pulses for one cycle with clear_pc = 0x1000; count = 0; the next alloc_tag = 1.
- Allocate dest x0 and complete it -> commits with ROB_data_valid = 0. A CDB hit on a free tag changes nothing.
- Hold rdy = 0 for 3 cycles with a ready head -> no commit and no state change; the commit occurs on the first edge after rdy = 1.
- Assert rst low mid-stream (4 busy entries) -> all outputs go to 0 immediately; rob_full = 0; alloc_tag = 1.
